uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 16 +
 rtl/fifo_mem.sv | 29 ++
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit FIFO.
// Drain FSM states and pointer sizing helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } drain_state_t;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Byte storage for the UART transmit FIFO.
// One write port, one registered read port, no reset.
module fifo_mem #(
    parameter int G_WIDTH = 8,
    parameter int G_DEPTH = 16,
    localparam int AW     = $clog2(G_DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [G_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [G_WIDTH-1:0] rd_data
);

    logic [G_WIDTH-1:0] mem [G_DEPTH];

    // Write on request; read data only updates when a byte is taken.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO that feeds a UART one byte at a time.
// Launches on an idle UART and waits for its busy handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int G_WORD_WIDTH   = 8,
    parameter int G_DEPTH        = 16,
    parameter int G_BUSY_TIMEOUT = 7
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [G_WORD_WIDTH-1:0]      i_wr_data,
    input  logic                         i_flush,
    output logic                         o_tx_en,
    output logic [G_WORD_WIDTH-1:0]      o_tx_data,
    input  logic                         i_tx_busy,
    output logic [$clog2(G_DEPTH+1)-1:0] o_count,
    output logic                         o_empty,
    output logic                         o_full,
    output logic                         o_tx_err
);

    localparam int AW = $clog2(G_DEPTH);
    localparam int PW = ptr_width(G_DEPTH);
    localparam int CW = $clog2(G_DEPTH + 1);
    localparam int TW = $clog2(G_BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(G_BUSY_TIMEOUT - 1);

    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           ptr_diff;
    logic [TW-1:0]           tmo_cnt;
    logic [G_WORD_WIDTH-1:0] head_q;
    logic                    data_vld;
    logic                    push;
    logic                    launch;
    logic                    tmo_hit;
    drain_state_t            state;
    drain_state_t            state_nxt;

    assign o_empty    = (wr_ptr == rd_ptr);
    assign o_full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_wr_ready = !o_full;
    assign push       = i_wr_valid && o_wr_ready && !i_flush;
    assign ptr_diff   = wr_ptr - rd_ptr;
    assign o_count    = CW'(ptr_diff);

    // Before the first launch the data bus reads as zero.
    assign o_tx_data  = data_vld ? head_q : '0;

    fifo_mem #(
        .G_WIDTH (G_WORD_WIDTH),
        .G_DEPTH (G_DEPTH)
    ) u_mem (
        .clk     (i_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (i_wr_data),
        .rd_en   (launch),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (head_q)
    );

    // Drain state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next drain state; flush blocks a launch in the same cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (i_tx_busy) begin
                    state_nxt = WAIT_LO;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_LO: begin
                if (!i_tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Drain control strobes derived from the current state.
    always_comb begin
        launch  = 1'b0;
        tmo_hit = 1'b0;
        unique case (state)
            IDLE:    launch  = !o_empty && !i_tx_busy && !i_flush;
            WAIT_HI: tmo_hit = !i_tx_busy && (tmo_cnt == TMO_LAST);
            default: ;
        endcase
    end

    // Read/write pointers; flush discards everything not yet launched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (i_flush) begin
                rd_ptr <= wr_ptr;
            end else if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Counts cycles spent waiting for the UART to raise busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_HI && !i_tx_busy && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Registered launch strobe, error pulse and data-valid flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tx_en  <= 1'b0;
            o_tx_err <= 1'b0;
            data_vld <= 1'b0;
        end else begin
            o_tx_en  <= launch;
            o_tx_err <= tmo_hit;
            data_vld <= data_vld | launch;
        end
    end

endmodule
